// File: rtl/video_timing_pkg.sv
// Shared types and helpers for the video timing generator and its sync delay line.
package video_timing_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } vt_state_e;

    localparam int unsigned SYNC_LAT_MIN = 1;
    localparam int unsigned SYNC_LAT_MAX = 8;

    // Bit positions inside the delayed sync bundle.
    localparam int unsigned SYNC_BITS = 3;
    localparam int unsigned SYNC_HS   = 2;
    localparam int unsigned SYNC_VS   = 1;
    localparam int unsigned SYNC_DE   = 0;

    function automatic int unsigned cnt_width(input int unsigned disp_width);
        return disp_width + 1;
    endfunction

    function automatic bit sync_lat_ok(input int unsigned lat);
        return (lat >= SYNC_LAT_MIN) && (lat <= SYNC_LAT_MAX);
    endfunction

endpackage

// File: rtl/video_sync_delay.sv
// Fixed-depth 3-bit shift register aligning sync/DE with pixel data read latency.
module video_sync_delay #(
    parameter int pDepth = 2
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic [2:0] iRstVal,
    input  logic [2:0] iD,
    output logic [2:0] oQ
);

    logic [2:0] stage_q [pDepth];

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            for (int i = 0; i < pDepth; i++) stage_q[i] <= iRstVal;
        end else begin
            stage_q[0] <= iD;
            for (int i = 1; i < pDepth; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign oQ = stage_q[pDepth-1];

endmodule

// File: rtl/video_timing_gen.sv
// Programmable H/V timing generator with per-frame shadowed timing, frame pacing
// and pixel FIFO underflow tracking.
module video_timing_gen
    import video_timing_pkg::*;
#(
    parameter int pHdisplayWidth = 11,
    parameter int pVdisplayWidth = 11,
    parameter int pSyncLatency   = 2,
    parameter int pFrameCntWidth = 16,
    parameter int pUflCntWidth   = 8
) (
    input  logic                        iClk,
    input  logic                        iRst,
    input  logic                        iEn,
    input  logic [pHdisplayWidth-1:0]   iHdisplay,
    input  logic [pVdisplayWidth-1:0]   iVdisplay,
    input  logic [pHdisplayWidth:0]     iHSyncStart,
    input  logic [pHdisplayWidth:0]     iHSyncEnd,
    input  logic [pHdisplayWidth:0]     iHSyncMax,
    input  logic [pVdisplayWidth:0]     iVSyncStart,
    input  logic [pVdisplayWidth:0]     iVSyncEnd,
    input  logic [pVdisplayWidth:0]     iVSyncMax,
    input  logic                        iHSyncPol,
    input  logic                        iVSyncPol,
    input  logic                        iDePol,
    input  logic [3:0]                  iFrameRepeat,
    input  logic                        iPixValid,
    input  logic                        iUflClr,
    output logic                        oPixRe,
    output logic [pHdisplayWidth:0]     oHPos,
    output logic [pVdisplayWidth:0]     oVPos,
    output logic                        oHSync,
    output logic                        oVSync,
    output logic                        oVde,
    output logic                        oFs,
    output logic                        oFe,
    output logic                        oFrameAdv,
    output logic [pFrameCntWidth-1:0]   oFrameCnt,
    output logic                        oUfl,
    output logic [pUflCntWidth-1:0]     oUflCnt
);

    localparam int HW = cnt_width(pHdisplayWidth);
    localparam int VW = cnt_width(pVdisplayWidth);

    if (!sync_lat_ok(pSyncLatency)) begin : g_bad_latency
        $error("video_timing_gen: pSyncLatency must be within 1..8");
    end

    vt_state_e state_q, state_d;
    logic [HW-1:0] hcnt_q, hcnt_d, hpos_q, hpos_d;
    logic [VW-1:0] vcnt_q, vcnt_d, vpos_q, vpos_d;
    logic [pHdisplayWidth-1:0] sh_hd_q;
    logic [pVdisplayWidth-1:0] sh_vd_q;
    logic [HW-1:0] sh_hss_q, sh_hse_q, sh_hmax_q;
    logic [VW-1:0] sh_vss_q, sh_vse_q, sh_vmax_q;
    logic [3:0]    sh_rep_q, rep_q, rep_d;
    logic          pix_re_q, pix_re_d, hs_q, hs_d, vs_q, vs_d;
    logic          fs_q, fs_d, fe_q, fe_d, adv_q, adv_d, ufl_q, ufl_d;
    logic [pFrameCntWidth-1:0] fcnt_q, fcnt_d;
    logic [pUflCntWidth-1:0]   ufl_cnt_q, ufl_cnt_d;
    logic          run, h_last, v_last, load_shadow;
    logic [SYNC_BITS-1:0] sync_raw, sync_dly;

    assign run         = (state_q == ST_RUN) && iEn;
    assign h_last      = (hcnt_q == sh_hmax_q);
    assign v_last      = (vcnt_q == sh_vmax_q);
    assign load_shadow = ((state_q == ST_IDLE) && iEn) || (run && h_last && v_last);

    always_comb begin
        state_d   = state_q;
        hcnt_d    = '0;
        vcnt_d    = '0;
        rep_d     = rep_q;
        fcnt_d    = fcnt_q;
        ufl_d     = ufl_q;
        ufl_cnt_d = ufl_cnt_q;
        adv_d     = 1'b0;

        case (state_q)
            ST_IDLE: if (iEn)  state_d = ST_RUN;
            ST_RUN:  if (!iEn) state_d = ST_IDLE;
            default:           state_d = ST_IDLE;
        endcase

        if (run) begin
            if (h_last) begin
                vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            end else begin
                hcnt_d = hcnt_q + 1'b1;
                vcnt_d = vcnt_q;
            end
        end

        pix_re_d = run && (hcnt_q < {1'b0, sh_hd_q}) && (vcnt_q < {1'b0, sh_vd_q});
        hs_d     = run && (hcnt_q >= sh_hss_q) && (hcnt_q < sh_hse_q);
        vs_d     = run && (vcnt_q >= sh_vss_q) && (vcnt_q < sh_vse_q);
        hpos_d   = run ? hcnt_q : '0;
        vpos_d   = run ? vcnt_q : '0;
        fs_d     = run && (hcnt_q == '0) && (vcnt_q == '0);
        fe_d     = run && h_last && v_last;

        // >= rather than == so lowering the repeat value mid-sequence cannot skip an advance.
        if (fe_d) begin
            fcnt_d = fcnt_q + 1'b1;
            if (rep_q >= sh_rep_q) begin
                rep_d = '0;
                adv_d = 1'b1;
            end else begin
                rep_d = rep_q + 1'b1;
            end
        end

        if (iUflClr) begin
            ufl_d     = 1'b0;
            ufl_cnt_d = '0;
        end else if (pix_re_q && !iPixValid) begin
            ufl_d = 1'b1;
            if (!(&ufl_cnt_q)) ufl_cnt_d = ufl_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q   <= ST_IDLE;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            hpos_q    <= '0;
            vpos_q    <= '0;
            pix_re_q  <= 1'b0;
            hs_q      <= 1'b0;
            vs_q      <= 1'b0;
            fs_q      <= 1'b0;
            fe_q      <= 1'b0;
            adv_q     <= 1'b0;
            rep_q     <= '0;
            fcnt_q    <= '0;
            ufl_q     <= 1'b0;
            ufl_cnt_q <= '0;
            sh_hd_q   <= '0;
            sh_vd_q   <= '0;
            sh_hss_q  <= '0;
            sh_hse_q  <= '0;
            sh_hmax_q <= '0;
            sh_vss_q  <= '0;
            sh_vse_q  <= '0;
            sh_vmax_q <= '0;
            sh_rep_q  <= '0;
        end else begin
            state_q   <= state_d;
            hcnt_q    <= hcnt_d;
            vcnt_q    <= vcnt_d;
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
            pix_re_q  <= pix_re_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            fs_q      <= fs_d;
            fe_q      <= fe_d;
            adv_q     <= adv_d;
            rep_q     <= rep_d;
            fcnt_q    <= fcnt_d;
            ufl_q     <= ufl_d;
            ufl_cnt_q <= ufl_cnt_d;
            if (load_shadow) begin
                sh_hd_q   <= iHdisplay;
                sh_vd_q   <= iVdisplay;
                sh_hss_q  <= iHSyncStart;
                sh_hse_q  <= iHSyncEnd;
                sh_hmax_q <= iHSyncMax;
                sh_vss_q  <= iVSyncStart;
                sh_vse_q  <= iVSyncEnd;
                sh_vmax_q <= iVSyncMax;
                sh_rep_q  <= iFrameRepeat;
            end
        end
    end

    assign sync_raw[SYNC_HS] = hs_q;
    assign sync_raw[SYNC_VS] = vs_q;
    assign sync_raw[SYNC_DE] = pix_re_q;

    video_sync_delay #(.pDepth(pSyncLatency)) u_sync_delay (
        .iClk    (iClk),
        .iRst    (iRst),
        .iRstVal (3'b000),
        .iD      (sync_raw),
        .oQ      (sync_dly)
    );

    // Polarity is applied after the delay so a change shows up on the very next output cycle.
    assign oHSync    = sync_dly[SYNC_HS] ^ ~iHSyncPol;
    assign oVSync    = sync_dly[SYNC_VS] ^ ~iVSyncPol;
    assign oVde      = sync_dly[SYNC_DE] ^ ~iDePol;
    assign oPixRe    = pix_re_q;
    assign oHPos     = hpos_q;
    assign oVPos     = vpos_q;
    assign oFs       = fs_q;
    assign oFe       = fe_q;
    assign oFrameAdv = adv_q;
    assign oFrameCnt = fcnt_q;
    assign oUfl      = ufl_q;
    assign oUflCnt   = ufl_cnt_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Self-checking bench: frame-position model plus directed scenario checks.
module tb_video_timing_gen;

    localparam int L = 2;

    logic        iClk = 1'b0, iRst = 1'b1, iEn = 1'b0;
    logic [10:0] iHdisplay = 11'd4, iVdisplay = 11'd2;
    logic [11:0] iHSyncStart = 12'd5, iHSyncEnd = 12'd6, iHSyncMax = 12'd7;
    logic [11:0] iVSyncStart = 12'd3, iVSyncEnd = 12'd4, iVSyncMax = 12'd4;
    logic        iHSyncPol = 1'b0, iVSyncPol = 1'b0, iDePol = 1'b0;
    logic [3:0]  iFrameRepeat = 4'd0;
    logic        iPixValid = 1'b1, iUflClr = 1'b0;
    logic        oPixRe, oHSync, oVSync, oVde, oFs, oFe, oFrameAdv, oUfl;
    logic [11:0] oHPos, oVPos;
    logic [15:0] oFrameCnt;
    logic [7:0]  oUflCnt;

    video_timing_gen #(.pSyncLatency(L)) dut (
        .iClk(iClk), .iRst(iRst), .iEn(iEn),
        .iHdisplay(iHdisplay), .iVdisplay(iVdisplay),
        .iHSyncStart(iHSyncStart), .iHSyncEnd(iHSyncEnd), .iHSyncMax(iHSyncMax),
        .iVSyncStart(iVSyncStart), .iVSyncEnd(iVSyncEnd), .iVSyncMax(iVSyncMax),
        .iHSyncPol(iHSyncPol), .iVSyncPol(iVSyncPol), .iDePol(iDePol),
        .iFrameRepeat(iFrameRepeat), .iPixValid(iPixValid), .iUflClr(iUflClr),
        .oPixRe(oPixRe), .oHPos(oHPos), .oVPos(oVPos),
        .oHSync(oHSync), .oVSync(oVSync), .oVde(oVde),
        .oFs(oFs), .oFe(oFe), .oFrameAdv(oFrameAdv), .oFrameCnt(oFrameCnt),
        .oUfl(oUfl), .oUflCnt(oUflCnt)
    );

    always #5 iClk = ~iClk;

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: position within the frame (-1 = idle) and the timing captured at frame start.
    typedef struct {
        int hd, vd, hss, hse, hmax, vss, vse, vmax, rep;
    } cfg_t;

    cfg_t cfg;
    int   m_pos = -1, m_shown = 0;
    int   e_pixre = 0, e_hpos = 0, e_vpos = 0, e_fs = 0, e_fe = 0, e_adv = 0;
    int   e_fcnt = 0, e_ufl = 0, e_uflcnt = 0;
    int   hist_hs[L+1], hist_vs[L+1], hist_de[L+1];
    int   m_h, m_v, m_len, m_hs, m_vs;
    bit   m_running;

    always @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            m_pos = -1; m_shown = 0;
            e_pixre = 0; e_hpos = 0; e_vpos = 0; e_fs = 0; e_fe = 0; e_adv = 0;
            e_fcnt = 0; e_ufl = 0; e_uflcnt = 0;
            for (int i = 0; i <= L; i++) begin hist_hs[i] = 0; hist_vs[i] = 0; hist_de[i] = 0; end
        end else begin
            if (iUflClr) begin
                e_ufl = 0; e_uflcnt = 0;
            end else if (e_pixre != 0 && !iPixValid) begin
                e_ufl = 1;
                if (e_uflcnt < 255) e_uflcnt++;
            end
            m_running = (m_pos >= 0) && iEn;
            m_len     = (cfg.hmax + 1) * (cfg.vmax + 1);
            m_h       = m_running ? m_pos % (cfg.hmax + 1) : 0;
            m_v       = m_running ? m_pos / (cfg.hmax + 1) : 0;
            e_pixre   = int'(m_running && m_h < cfg.hd && m_v < cfg.vd);
            m_hs      = int'(m_running && m_h >= cfg.hss && m_h < cfg.hse);
            m_vs      = int'(m_running && m_v >= cfg.vss && m_v < cfg.vse);
            e_hpos    = m_h;
            e_vpos    = m_v;
            e_fs      = int'(m_running && m_pos == 0);
            e_fe      = int'(m_running && m_pos == m_len - 1);
            e_adv     = 0;
            if (e_fe != 0) begin
                e_fcnt = (e_fcnt + 1) % 65536;
                m_shown++;
                if (m_shown > cfg.rep) begin e_adv = 1; m_shown = 0; end
            end
            for (int i = L; i > 0; i--) begin
                hist_hs[i] = hist_hs[i-1]; hist_vs[i] = hist_vs[i-1]; hist_de[i] = hist_de[i-1];
            end
            hist_hs[0] = m_hs; hist_vs[0] = m_vs; hist_de[0] = e_pixre;
            if (!iEn) m_pos = -1;
            else if (m_pos < 0 || m_pos == m_len - 1) begin
                m_pos = 0;
                cfg.hd = int'(iHdisplay); cfg.vd = int'(iVdisplay);
                cfg.hss = int'(iHSyncStart); cfg.hse = int'(iHSyncEnd); cfg.hmax = int'(iHSyncMax);
                cfg.vss = int'(iVSyncStart); cfg.vse = int'(iVSyncEnd); cfg.vmax = int'(iVSyncMax);
                cfg.rep = int'(iFrameRepeat);
            end else m_pos++;
        end
    end

    always @(posedge iClk) begin
        #1;
        chk("pixre", 32'(oPixRe), e_pixre);
        chk("hpos", 32'(oHPos), e_hpos);
        chk("vpos", 32'(oVPos), e_vpos);
        chk("fs", 32'(oFs), e_fs);
        chk("fe", 32'(oFe), e_fe);
        chk("adv", 32'(oFrameAdv), e_adv);
        chk("fcnt", 32'(oFrameCnt), e_fcnt);
        chk("ufl", 32'(oUfl), e_ufl);
        chk("uflcnt", 32'(oUflCnt), e_uflcnt);
        chk("hsync", 32'(oHSync), 32'(hist_hs[L] ^ int'(!iHSyncPol)));
        chk("vsync", 32'(oVSync), 32'(hist_vs[L] ^ int'(!iVSyncPol)));
        chk("vde", 32'(oVde), 32'(hist_de[L] ^ int'(!iDePol)));
    end

    task automatic cyc();
        @(posedge iClk); #1;
    endtask

    int n_pix, n_hs, n_vs, n_de, n_fs, n_fe, t_fs0, t_fs1, t_fe0, t_fe1, t, mx, mask, n_adv, n;
    bit ok;

    initial begin
        // Reset with all polarities low: syncs must sit at the inactive (high) level.
        cyc();
        chk("rst_hsync", 32'(oHSync), 1); chk("rst_vsync", 32'(oVSync), 1);
        chk("rst_vde", 32'(oVde), 1); chk("rst_pixre", 32'(oPixRe), 0);
        chk("rst_fcnt", 32'(oFrameCnt), 0); chk("rst_uflcnt", 32'(oUflCnt), 0);
        @(negedge iClk);
        iHSyncPol = 1; iVSyncPol = 1; iDePol = 1;
        @(negedge iClk); iRst = 0;
        @(negedge iClk); iEn = 1;

        // Two frames of basic timing.
        n_pix = 0; n_hs = 0; n_vs = 0; n_de = 0; n_fs = 0; n_fe = 0; ok = 0;
        for (t = 0; t < 200 && !ok; t++) begin
            cyc();
            n_pix += int'(oPixRe); n_hs += int'(oHSync); n_vs += int'(oVSync); n_de += int'(oVde);
            if (oFs) begin if (n_fs == 0) t_fs0 = t; else t_fs1 = t; n_fs++; end
            if (oFe) begin if (n_fe == 0) t_fe0 = t; else t_fe1 = t; n_fe++; ok = (n_fe == 2); end
        end
        chk("basic_timeout", 32'(ok), 1);
        @(negedge iClk); iEn = 0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            n_pix += int'(oPixRe); n_hs += int'(oHSync); n_vs += int'(oVSync); n_de += int'(oVde);
            n_fs += int'(oFs); n_fe += int'(oFe);
        end
        chk("basic_pixre", n_pix, 16); chk("basic_hsync", n_hs, 10);
        chk("basic_vsync", n_vs, 16); chk("basic_vde", n_de, 16);
        chk("basic_nfs", n_fs, 2); chk("basic_nfe", n_fe, 2);
        chk("basic_fs_gap", t_fs1 - t_fs0, 40); chk("basic_fe_gap", t_fe1 - t_fe0, 40);
        chk("basic_fcnt", 32'(oFrameCnt), 2);

        // Polarity flip mid-run: exactly one low hsync cycle per line.
        @(negedge iClk); iEn = 1;
        repeat (13) @(negedge iClk);
        iHSyncPol = 0;
        n_hs = 0;
        for (int i = 0; i < 40; i++) begin cyc(); n_hs += int'(!oHSync); end
        chk("pol_hsync_low", n_hs, 5);
        @(negedge iClk); iHSyncPol = 1;

        // Shadow update: new Hdisplay only from the next frame.
        ok = 0;
        for (t = 0; t < 200 && !ok; t++) begin
            cyc(); ok = oPixRe && oVPos == 1 && oHPos == 0;
        end
        chk("shadow_sync_timeout", 32'(ok), 1);
        @(negedge iClk); iHdisplay = 11'd3;
        mx = 0; ok = 0;
        for (t = 0; t < 100 && !ok; t++) begin
            cyc();
            ok = oFs;
            if (!ok && oPixRe && int'(oHPos) > mx) mx = int'(oHPos);
        end
        chk("shadow_old_maxh", mx, 3);
        mx = 0; n_pix = 0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) cyc();
            n_pix += int'(oPixRe);
            if (oPixRe && int'(oHPos) > mx) mx = int'(oHPos);
        end
        chk("shadow_new_pix", n_pix, 6); chk("shadow_new_maxh", mx, 2);

        // Frame pacing: each source frame shown three times.
        @(negedge iClk); iEn = 0; iHdisplay = 11'd4; iFrameRepeat = 4'd2;
        repeat (4) @(negedge iClk);
        iEn = 1;
        n_fe = 0; mask = 0; n_adv = 0;
        for (t = 0; t < 400 && n_fe < 6; t++) begin
            cyc();
            n_adv += int'(oFrameAdv);
            if (oFe) begin n_fe++; if (oFrameAdv) mask |= 1 << (n_fe - 1); end
        end
        chk("pace_nfe", n_fe, 6); chk("pace_mask", mask, 36); chk("pace_nadv", n_adv, 2);
        @(negedge iClk); iFrameRepeat = 4'd0;

        // Underflow: three, then saturation, then clear beating a coincident underflow.
        n = 0;
        for (t = 0; t < 400 && n < 3; t++) begin
            @(negedge iClk);
            if (oPixRe) begin iPixValid = 0; n++; end else iPixValid = 1;
        end
        @(negedge iClk); iPixValid = 1;
        chk("ufl_flag", 32'(oUfl), 1); chk("ufl_cnt3", 32'(oUflCnt), 3);
        n = 0;
        for (t = 0; t < 3000 && n < 300; t++) begin
            @(negedge iClk);
            if (oPixRe) begin iPixValid = 0; n++; end else iPixValid = 1;
        end
        @(negedge iClk); iPixValid = 1;
        chk("ufl_sat", 32'(oUflCnt), 255);
        ok = 0;
        for (t = 0; t < 100 && !ok; t++) begin @(negedge iClk); ok = oPixRe; end
        iPixValid = 0; iUflClr = 1;
        @(negedge iClk); iPixValid = 1; iUflClr = 0;
        chk("ufl_clr_flag", 32'(oUfl), 0); chk("ufl_clr_cnt", 32'(oUflCnt), 0);

        // Enable drop mid-line, then re-enable.
        ok = 0;
        for (t = 0; t < 200 && !ok; t++) begin @(negedge iClk); ok = oPixRe && oHPos == 1; end
        chk("en_sync_timeout", 32'(ok), 1);
        iEn = 0;
        cyc();
        chk("en_off_pixre", 32'(oPixRe), 0); chk("en_off_hpos", 32'(oHPos), 0);
        chk("en_off_vpos", 32'(oVPos), 0);
        @(negedge iClk); iEn = 1;
        cyc(); chk("en_fs_early", 32'(oFs), 0);
        cyc(); chk("en_fs", 32'(oFs), 1);

        // Async reset mid-frame, vsync polarity low to see the inactive-high level.
        repeat (15) @(negedge iClk);
        iVSyncPol = 0;
        #2 iRst = 1;
        #1;
        chk("arst_pixre", 32'(oPixRe), 0); chk("arst_hpos", 32'(oHPos), 0);
        chk("arst_vpos", 32'(oVPos), 0); chk("arst_fs", 32'(oFs), 0);
        chk("arst_fe", 32'(oFe), 0); chk("arst_adv", 32'(oFrameAdv), 0);
        chk("arst_fcnt", 32'(oFrameCnt), 0); chk("arst_ufl", 32'(oUfl), 0);
        chk("arst_hsync", 32'(oHSync), 0); chk("arst_vsync", 32'(oVSync), 1);
        chk("arst_vde", 32'(oVde), 0);
        repeat (3) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Parametrised, single-clock successor to the fixed video sync generator and the fixed 2-stage sync delay line in the video TX path.
- Generates H/V sync, data-enable and pixel-read strobe from a programmable timing set that is shadowed per frame.
- Adds programmable sync polarity, a parameterised output alignment delay, frame pacing (the FPS adjustment hook) and pixel-FIFO underflow detection.
- Sits in the video clock domain, between the dual-clock pixel FIFO read side and the TFT output buffers.

Parameters:
- pHdisplayWidth, 11: bit width of horizontal display size; counters are pHdisplayWidth+1 bits.
- pVdisplayWidth, 11: bit width of vertical display size; counters are pVdisplayWidth+1 bits.
- pSyncLatency, 2: cycles from oPixRe to oHSync/oVSync/oVde; legal range 1..8; matches the pixel FIFO read latency.
- pFrameCntWidth, 16: width of the free-running frame counter.
- pUflCntWidth, 8: width of the saturating underflow counter.

Ports:
- iClk  in  1  video pixel clock
- iRst  in  1  reset, asynchronous, active-high
- iEn  in  1  timing enable; low holds the generator idle
- iHdisplay  in  pHdisplayWidth  active pixels per line
- iVdisplay  in  pVdisplayWidth  active lines per frame
- iHSyncStart, iHSyncEnd, iHSyncMax  in  pHdisplayWidth+1 each  hsync window [start,end); last h count
- iVSyncStart, iVSyncEnd, iVSyncMax  in  pVdisplayWidth+1 each  vsync window [start,end); last v count
- iHSyncPol, iVSyncPol, iDePol  in  1 each  1 = active-high output
- iFrameRepeat  in  4  each source frame is shown iFrameRepeat+1 times
- iPixValid  in  1  pixel FIFO holds data (not empty); sampled with oPixRe
- iUflClr  in  1  clears the underflow flag and counter
- oPixRe  out  1  pixel FIFO read strobe (undelayed)
- oHPos  out  pHdisplayWidth+1  current h count (undelayed)
- oVPos  out  pVdisplayWidth+1  current v count (undelayed)
- oHSync, oVSync, oVde  out  1 each  delayed by pSyncLatency, polarity applied
- oFs  out  1  one-cycle frame-start pulse (undelayed)
- oFe  out  1  one-cycle frame-end pulse (undelayed)
- oFrameAdv  out  1  one-cycle pulse telling the DMA to swap or advance the frame buffer
- oFrameCnt  out  pFrameCntWidth  count of displayed frames, wraps
- oUfl  out  1  sticky underflow flag
- oUflCnt  out  pUflCntWidth  saturating underflow count

Behaviour:
- Reset values: hcnt=vcnt=0, oPixRe=0, oFs=oFe=oFrameAdv=0, oFrameCnt=0, oUfl=0, oUflCnt=0, repeat counter=0, delay line cleared.
- While in reset or delay line cleared, oHSync/oVSync/oVde drive the inactive level of the current polarity input (~Pol).
- States:
  - IDLE: iEn=0; counters held at 0; all pulses 0.
  - RUN: iEn=1.
  - IDLE->RUN loads the shadow timing registers; the first RUN cycle is hcnt=0, vcnt=0.
  - RUN->IDLE (iEn falls) returns to IDLE on the next cycle, discarding the frame.
- Counting:
  - hcnt runs 0..HSyncMax, then wraps to 0.
  - vcnt increments on each h wrap and runs 0..VSyncMax, then wraps to 0.
  - Shadow registers reload only on the cycle where both counters wrap, and on IDLE->RUN. Mid-frame input changes have no effect until the next frame.
- Registered decode of the counter state in cycle t appears in cycle t+1:
  - active = hcnt<Hdisplay && vcnt<Vdisplay
  - hs = HSyncStart<=hcnt<HSyncEnd
  - vs = VSyncStart<=vcnt<VSyncEnd
- Outputs from the decode:
  - oPixRe = active.
  - oHPos/oVPos are registered with oPixRe.
  - oFs at hcnt=0,vcnt=0; oFe at hcnt=HSyncMax,vcnt=VSyncMax.
- Delay line: oHSync = hs^~iHSyncPol (same form for V and DE), registered through pSyncLatency stages after oPixRe, so oVde(t+pSyncLatency) = oPixRe(t).
- Polarity inputs are applied at the output stage and take effect immediately.
- Frame pacing:
  - On each oFe the repeat counter increments.
  - When it equals the shadowed iFrameRepeat, it clears and oFrameAdv pulses coincident with oFe.
  - iFrameRepeat=0 gives oFrameAdv on every oFe.
- oFrameCnt increments on every oFe and wraps at 2^pFrameCntWidth.
- Underflow:
  - oPixRe=1 with iPixValid=0 in the same cycle sets oUfl and increments oUflCnt, which saturates at all-ones.
  - iUflClr has priority over a coincident underflow: the result is cleared, with no increment that cycle.
- Degenerate configs are undefined and untested: HSyncMax<Hdisplay, or Start>End.
- Async reset at any point returns to the reset values immediately; no pulse is emitted.

Decomposition:
- Shared package video_timing_pkg holds:
  - state encoding (IDLE, RUN);
  - the pSyncLatency legal-range check;
  - the width helper localparams.
- One sub-module: video_sync_delay, a pSyncLatency-deep, 3-bit-wide shift register with async clear and a per-bit reset value input. It is reused by other video output paths.

Test Plan:
- Common config: Hdisplay=4, HSync 5/6/Max 7, Vdisplay=2, VSync 3/4/Max 4, all Pol=1, pSyncLatency=2. Frame = 8×5 = 40 cycles.
- Basic timing: run 2 frames -> per line oPixRe high 4 cycles (lines 0–1 only), oHSync high 1 cycle per line, oVSync high 8 cycles, oVde exactly oPixRe delayed 2, oFs/oFe 40 cycles apart, oFrameCnt=2.
- Polarity: set iHSyncPol=0 mid-run -> oHSync low only at hcnt=5 (delayed), otherwise high, from the next output cycle; other signals unchanged.
- Shadow update: change Hdisplay to 3 at vcnt=1 -> current frame keeps 4-pixel lines; next frame shows 3-pixel lines; the change is coincident with the frame wrap.
- Frame pacing: iFrameRepeat=2, run 6 frames -> oFrameAdv on the 3rd and 6th oFe only.
- Underflow: hold iPixValid=0 for 3 oPixRe cycles -> oUfl=1, oUflCnt=3. Then hold iPixValid=0 for 300 active cycles -> oUflCnt=255. Then iUflClr coincident with an underflow -> 0/0.
- Enable and reset: deassert iEn mid-line -> next cycle oPixRe=0 and counters 0; re-enable -> oFs one cycle later. Async iRst mid-frame -> all outputs at their reset values within the same cycle, with syncs at the inactive level.
